// File: rtl/q_meter.sv
// Measurement front end: waits for i_ref to settle, averages 2**LOG2_SAMPLES converter samples, reports q_measured.
// Optional acquisition timeout is compiled in with `define QMETER_TIMEOUT_EN.
module q_meter #(
   parameter int BUS_WIDTH      = 10,
   parameter int SETTLE_CYCLES  = 16,
   parameter int LOG2_SAMPLES   = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [BUS_WIDTH-1:0] i_ref,
   input  logic                 adc_valid,
   input  logic [BUS_WIDTH-1:0] adc_data,
   output logic [BUS_WIDTH-1:0] q_measured,
   output logic                 ready,
   output logic                 busy,
   output logic                 timeout
);

   localparam int AW = BUS_WIDTH + LOG2_SAMPLES;
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int CW = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] LAST_SAMPLE = CW'((1 << LOG2_SAMPLES) - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, ACQUIRE, REPORT} state_t;

   state_t               state;
   logic [BUS_WIDTH-1:0] i_ref_q;
   logic [SW-1:0]        settle_cnt;
   logic [CW-1:0]        sample_cnt;
   logic [AW-1:0]        acc;
   logic [AW-1:0]        acc_sum;
   logic                 change;

`ifdef QMETER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] idle_cnt;
`endif

   assign change  = (i_ref != i_ref_q);
   assign acc_sum = acc + AW'(adc_data);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         i_ref_q    <= '0;
         settle_cnt <= '0;
         sample_cnt <= '0;
         acc        <= '0;
         q_measured <= '0;
         ready      <= 1'b0;
         busy       <= 1'b0;
         timeout    <= 1'b0;
`ifdef QMETER_TIMEOUT_EN
         idle_cnt   <= '0;
`endif
      end else begin
         i_ref_q <= i_ref;
         ready   <= 1'b0;
         timeout <= 1'b0;
         if (!enable) begin
            state      <= IDLE;
            busy       <= 1'b0;
            acc        <= '0;
            sample_cnt <= '0;
            settle_cnt <= '0;
         end else if (change) begin
            // Any reference change restarts the settle window; partial sums are stale.
            state      <= SETTLE;
            busy       <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
            acc        <= '0;
            sample_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state      <= SETTLE;
                  busy       <= 1'b1;
                  settle_cnt <= SETTLE_LOAD;
               end
               SETTLE: begin
                  if (settle_cnt == '0) begin
                     state      <= ACQUIRE;
                     acc        <= '0;
                     sample_cnt <= '0;
`ifdef QMETER_TIMEOUT_EN
                     idle_cnt   <= '0;
`endif
                  end else begin
                     settle_cnt <= settle_cnt - 1'b1;
                  end
               end
               ACQUIRE: begin
                  if (adc_valid) begin
`ifdef QMETER_TIMEOUT_EN
                     idle_cnt <= '0;
`endif
                     // The final sample is folded in directly so the report lands one cycle later.
                     if (sample_cnt == LAST_SAMPLE) begin
                        q_measured <= acc_sum[AW-1:LOG2_SAMPLES];
                        ready      <= 1'b1;
                        state      <= REPORT;
                        busy       <= 1'b0;
                     end else begin
                        acc        <= acc_sum;
                        sample_cnt <= sample_cnt + 1'b1;
                     end
                  end
`ifdef QMETER_TIMEOUT_EN
                  else if (idle_cnt == TIMEOUT_LAST) begin
                     // All ones pushes the controller toward a lower i_ref.
                     q_measured <= '1;
                     ready      <= 1'b1;
                     timeout    <= 1'b1;
                     state      <= REPORT;
                     busy       <= 1'b0;
                  end else begin
                     idle_cnt <= idle_cnt + 1'b1;
                  end
`endif
               end
               REPORT: begin
                  state      <= SETTLE;
                  busy       <= 1'b1;
                  settle_cnt <= SETTLE_LOAD;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_q_meter.sv
// Bench for q_meter: vector table of sample sets plus hand-written restart, enable, reset and timeout sequences.
module tb_q_meter;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [9:0] i_ref;
   logic       adc_valid;
   logic [9:0] adc_data;
   logic [9:0] q_measured;
   logic       ready;
   logic       busy;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [9:0] s[4];
      logic [9:0] q;
   } vec_t;

   typedef struct {
      logic [9:0] q;
      logic       to;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[5];

   q_meter #(.BUS_WIDTH(10), .SETTLE_CYCLES(16), .LOG2_SAMPLES(2), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .enable(enable), .i_ref(i_ref),
      .adc_valid(adc_valid), .adc_data(adc_data),
      .q_measured(q_measured), .ready(ready), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every ready pulse must match the oldest queued expectation.
   task automatic monitor();
      exp_t e;
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (ready) begin
            chk("ready_single", {31'd0, prev}, 0);
            if (sb.size() == 0) chk("unexpected_ready", {31'd0, ready}, 0);
            else begin
               e = sb.pop_front();
               chk("q_measured", {22'd0, q_measured}, {22'd0, e.q});
               chk("timeout_flag", {31'd0, timeout}, {31'd0, e.to});
            end
         end else if (timeout) begin
            chk("timeout_alone", {31'd0, timeout}, 0);
         end
         prev = ready;
      end
   endtask

   // Called on the first ACQUIRE cycle; garbage is driven again afterwards.
   task automatic acquire4(input vec_t v);
      exp_t e;
      chk("busy_acq", {31'd0, busy}, 1);
      for (int k = 0; k < 4; k++) begin
         adc_valid = 1'b1;
         adc_data  = v.s[k];
         if (k == 3) begin
            e.q = v.q; e.to = 1'b0;
            sb.push_back(e);
         end
         tick();
      end
      adc_data = 10'd1000;
      chk("ready_latency", {31'd0, ready}, 1);
   endtask

   initial begin
      vecs[0] = '{'{10'd100, 10'd102, 10'd104, 10'd106}, 10'd103};
      vecs[1] = '{'{10'd1023, 10'd1023, 10'd1023, 10'd1023}, 10'd1023};
      vecs[2] = '{'{10'd1, 10'd1, 10'd1, 10'd2}, 10'd1};
      vecs[3] = '{'{10'd0, 10'd0, 10'd0, 10'd3}, 10'd0};
      vecs[4] = '{'{10'd7, 10'd8, 10'd9, 10'd10}, 10'd8};

      rst = 1'b1; enable = 1'b0; i_ref = 10'd512; adc_valid = 1'b0; adc_data = 10'd0;
      fork monitor(); join_none
      repeat (3) tick();
      chk("rst_q", {22'd0, q_measured}, 0);
      chk("rst_ready", {31'd0, ready}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_timeout", {31'd0, timeout}, 0);
      rst = 1'b0;
      repeat (3) tick();
      chk("idle_busy", {31'd0, busy}, 0);

      // Garbage with valid high outside ACQUIRE must be ignored.
      adc_valid = 1'b1; adc_data = 10'd1000;
      enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         repeat (17) tick();
         acquire4(vecs[i]);
      end

      // Reference change after two accepted samples.
      repeat (17) tick();
      adc_data = 10'd500;
      tick(); tick();
      i_ref = 10'd256; adc_data = 10'd1000;
      repeat (17) tick();
      acquire4('{'{10'd20, 10'd20, 10'd20, 10'd24}, 10'd21});

      // Change during REPORT, then again mid-SETTLE: counter reloads.
      i_ref = 10'd300;
      repeat (5) tick();
      i_ref = 10'd310;
      repeat (17) tick();
      acquire4('{'{10'd7, 10'd8, 10'd9, 10'd10}, 10'd8});

      // Enable drop mid-ACQUIRE.
      repeat (17) tick();
      adc_data = 10'd40;
      tick(); tick();
      enable = 1'b0; adc_data = 10'd1000;
      tick();
      chk("drop_busy", {31'd0, busy}, 0);
      repeat (5) tick();
      chk("drop_q_hold", {22'd0, q_measured}, 8);
      enable = 1'b1;
      repeat (17) tick();
      acquire4('{'{10'd40, 10'd41, 10'd42, 10'd43}, 10'd41});

      // Asynchronous reset mid-ACQUIRE.
      repeat (17) tick();
      adc_data = 10'd5;
      tick(); tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_q", {22'd0, q_measured}, 0);
      chk("arst_ready", {31'd0, ready}, 0);
      chk("arst_busy", {31'd0, busy}, 0);
      enable = 1'b0;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("arst_idle", {31'd0, busy}, 0);

      // No converter samples in ACQUIRE.
      adc_valid = 1'b0;
      enable = 1'b1;
      repeat (17) tick();
`ifdef QMETER_TIMEOUT_EN
      begin
         exp_t e;
         e.q = 10'h3FF; e.to = 1'b1;
         sb.push_back(e);
      end
      repeat (7) tick();
      chk("to_not_early", {31'd0, ready}, 0);
      tick();
      chk("to_ready", {31'd0, ready}, 1);
      chk("to_timeout", {31'd0, timeout}, 1);
`else
      repeat (40) tick();
      chk("wait_busy", {31'd0, busy}, 1);
      chk("wait_no_ready", {31'd0, ready}, 0);
`endif
      enable = 1'b0;
      repeat (3) tick();
      chk("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
